// File: rtl/csa64_serial_sub.sv
// Digit-serial subtractor: diff = op1 - op2 computed as op1 + ~op2 + 1,
// DIGIT bits per cycle through one registered ripple slice.
module csa64_serial_sub #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    count;

  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] res_next;

  // The only adder is this DIGIT-bit slice; carry between digits goes through the carry register.
  assign digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign res_next  = {digit_sum[DIGIT-1:0], res_sr[WIDTH-1:DIGIT]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= op1;
            b_sr     <= ~op2;
            carry    <= 1'b1;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= digit_sum[DIGIT];
          count  <= count + 1'b1;
          // Final carry of 1 means no borrow occurred.
          if (count == LAST) begin
            diff      <= res_next;
            bout      <= ~digit_sum[DIGIT];
            zero      <= (res_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa64_serial_sub.sv
// Scoreboard bench for csa64_serial_sub: directed and random subtractions,
// latency, backpressure and asynchronous reset abort.
module tb_csa64_serial_sub;

  localparam int WIDTH   = 64;
  localparam int LATENCY = 17;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             b;
    logic             z;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  csa64_serial_sub #(.WIDTH(WIDTH), .DIGIT(4)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.d = a - b;
    e.b = (a < b);
    e.z = (e.d == '0);
    return e;
  endfunction

  // Accept one operation, wait for the result, optionally hold it under
  // backpressure, then retire it against the scoreboard.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!in_ready) begin
      check_output("in_ready_timeout", 0, 1);
      return;
    end
    out_ready = (hold == 0);
    op1       = a;
    op2       = b;
    in_valid  = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clock); #1;
    in_valid = 1'b0;
    op1      = {$urandom, $urandom};
    op2      = {$urandom, $urandom};
    n = 1;
    while (!out_valid && n < 40) begin
      if (n == 8) check_output("in_ready_run", in_ready, 0);
      @(posedge clock); #1; n++;
    end
    if (!out_valid) begin
      check_output("out_valid_timeout", 0, 1);
      return;
    end
    check_output("latency", n, LATENCY);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op1      = {$urandom, $urandom};
      @(posedge clock); #1;
      in_valid = 1'b0;
      check_output("hold_valid", out_valid, 1);
      check_output("hold_in_ready", in_ready, 0);
      check_output("hold_diff", diff, sb[0].d);
      check_output("hold_bout", bout, sb[0].b);
      check_output("hold_zero", zero, sb[0].z);
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    check_output("diff", diff, e.d);
    check_output("bout", bout, e.b);
    check_output("zero", zero, e.z);
    @(posedge clock); #1;
    check_output("out_valid_drop", out_valid, 0);
    check_output("in_ready_back", in_ready, 1);
    check_output("diff_kept", diff, e.d);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clock     = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op1       = '0;
    op2       = '0;
    repeat (3) @(posedge clock);
    #1;
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    check_output("reset_diff", diff, 0);
    check_output("reset_bout", bout, 0);
    check_output("reset_zero", zero, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    apply_stimulus(64'd5, 64'd3, 0);
    apply_stimulus(64'd3, 64'd5, 0);
    apply_stimulus(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);
    apply_stimulus(64'd0, 64'd0, 0);
    apply_stimulus(64'h8000_0000_0000_0000, 64'd1, 0);
    apply_stimulus(64'd0, 64'd1, 0);
    apply_stimulus(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 5);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus({$urandom, $urandom}, {$urandom, $urandom}, i % 3);
    end

    // Abort an operation partway through RUN with an asynchronous reset.
    op1      = 64'hFFFF_0000_FFFF_0000;
    op2      = 64'h0000_0000_0000_0001;
    in_valid = 1'b1;
    sb.push_back(model(op1, op2));
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_output("abort_out_valid", out_valid, 0);
    check_output("abort_diff", diff, 0);
    check_output("abort_in_ready", in_ready, 1);
    check_output("abort_bout", bout, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    apply_stimulus(64'h0000_0000_0000_0100, 64'h0000_0000_0000_00FF, 0);
    apply_stimulus(64'd7, 64'd9, 2);

    check_output("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csa64_serial_sub.md
Name: csa64_serial_sub

Overview:
- Digit-serial 64-bit subtractor; the inverse of the parallel 64-bit carry-select adder datapath.
- Computes diff = op1 - op2 by two's-complement addition of ~op2 with carry-in 1.
- Processes DIGIT bits per cycle through one registered ripple slice, trading latency for area.
- Sits beside the adder in the ALU datapath; valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 64, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH must be a multiple of DIGIT.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on op1/op2.
- in_ready  output  1  block can accept operands.
- op1  input  WIDTH  minuend.
- op2  input  WIDTH  subtrahend.
- out_valid  output  1  result valid on diff/bout/zero.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  op1 - op2, modulo 2^WIDTH.
- bout  output  1  borrow out: 1 when op1 < op2 (unsigned).
- zero  output  1  1 when diff == 0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, diff=0, bout=0, zero=0.
  - Operand shift registers, digit counter and carry register clear to 0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op1 into shift register A and ~op2 into shift register B; set carry=1 and count=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: {c, s} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry.
  - Shift A and B right by DIGIT; shift s into the top DIGIT bits of the result register; carry<=c; count++.
  - On the cycle count reaches WIDTH/DIGIT-1, the result register is complete; go to DONE.
  - On that transition: diff is loaded, bout<=~c, zero<=(completed result == 0).
- DONE:
  - out_valid=1; in_ready=0.
  - diff, bout and zero hold stable while out_valid && !out_ready.
  - On out_ready: go to IDLE and drop out_valid next cycle. diff, bout and zero keep their last value until the next DONE.
- Latency:
  - Handshake accepted in cycle T means out_valid is first high in cycle T+WIDTH/DIGIT+1, i.e. T+17 at defaults.
  - Throughput is one operation per WIDTH/DIGIT+2 cycles minimum.
- Simultaneous events:
  - in_valid is ignored in RUN and DONE; op1/op2 changes there have no effect.
  - out_ready with out_valid low has no effect.
  - No bypass from DONE to RUN: a new op is accepted no earlier than the cycle after the result handshake.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH. Final carry 1 means no borrow.
  - Carry propagates across digit boundaries through the carry register only, never combinationally across digits.
- Diff/result register updates only in RUN/DONE transitions and reset.

Test Plan:
- op1=5, op2=3, out_ready=1 -> diff=0x2, bout=0, zero=0; out_valid exactly 17 cycles after accept, high 1 cycle.
- op1=3, op2=5 -> diff=0xFFFF_FFFF_FFFF_FFFE, bout=1, zero=0.
- op1=op2=0x1234_5678_9ABC_DEF0 -> diff=0, zero=1, bout=0. Also op1=op2=0 -> diff=0, zero=1, bout=0.
- Full-length borrow chain:
  - op1=0x8000_0000_0000_0000, op2=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0.
  - op1=0, op2=1 -> diff=all ones, bout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> diff/bout/zero stable, in_ready=0, in_valid pulses ignored; on release in_ready=1 next cycle.
- Reset mid-RUN: assert reset_n=0 on RUN cycle 8 -> out_valid=0, diff=0, in_ready=1 immediately (async). A new op after release computes correctly with no residue.
